// File: rtl/wb_basicio_gen_if.sv
// Wishbone classic bus bundle for the basic I/O peripheral.
// Master drives request fields; slave returns ack and read data.
interface wb_basicio_gen_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_basicio_gen.sv
// Wishbone basic I/O: LEDs, synchronised switches and debounced
// buttons with per-button edge select, W1C pending and mask.
module wb_basicio_gen #(
  parameter int LED_W      = 8,
  parameter int SW_W       = 8,
  parameter int BTN_N      = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  wb_basicio_gen_if.slave    wb,
  output logic [LED_W-1:0]   led,
  input  logic [SW_W-1:0]    sw,
  input  logic [BTN_N-1:0]   btn,
  output logic               irq
);

  localparam logic [DEB_W-1:0] DEB_MAX =
    DEB_W'(DEB_CYCLES - 1);

  localparam logic [7:0] A_LED  = 8'h00;
  localparam logic [7:0] A_SW   = 8'h04;
  localparam logic [7:0] A_BTN  = 8'h08;
  localparam logic [7:0] A_PEND = 8'h0C;
  localparam logic [7:0] A_MASK = 8'h10;
  localparam logic [7:0] A_EDGE = 8'h14;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic [BTN_N-1:0]  btn_s1_q, btn_s2_q;
  logic [BTN_N-1:0]  st_q, st_d;
  logic [BTN_N-1:0]  st_dly_q;
  logic [BTN_N-1:0]  pend_q, pend_d;
  logic [BTN_N-1:0]  mask_q, mask_d;
  logic [BTN_N-1:0]  edge_q, edge_d;
  logic [DEB_W-1:0]  cnt_q [BTN_N];
  logic [DEB_W-1:0]  cnt_d [BTN_N];

  logic              req, wr, rd;
  logic [7:0]        adr;
  logic [31:0]       wm;
  logic [31:0]       rdata;
  logic              hit_led, hit_sw, hit_btn;
  logic              hit_pend, hit_mask, hit_edge;
  logic [BTN_N-1:0]  clr, ev;

  logic              unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[31:8], wb.wb_dat_i};

  assign req = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr  = req & wb.wb_we_i;
  assign rd  = req & ~wb.wb_we_i;
  assign adr = wb.wb_adr_i[7:0];
  assign wm  = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};

  assign hit_led  = (adr == A_LED);
  assign hit_sw   = (adr == A_SW);
  assign hit_btn  = (adr == A_BTN);
  assign hit_pend = (adr == A_PEND);
  assign hit_mask = (adr == A_MASK);
  assign hit_edge = (adr == A_EDGE);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_led:  rdata[LED_W-1:0] = led_q;
      hit_sw:   rdata[SW_W-1:0]  = sw_s2_q;
      hit_btn:  rdata[BTN_N-1:0] = st_q;
      hit_pend: rdata[BTN_N-1:0] = pend_q;
      hit_mask: rdata[BTN_N-1:0] = mask_q;
      hit_edge: rdata[BTN_N-1:0] = edge_q;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    ack_d  = req;
    dat_d  = rd ? rdata : dat_q;
    led_d  = led_q;
    mask_d = mask_q;
    edge_d = edge_q;
    clr    = '0;
    if (wr && hit_led)
      led_d = (led_q & ~wm[LED_W-1:0])
            | (wb.wb_dat_i[LED_W-1:0] & wm[LED_W-1:0]);
    if (wr && hit_mask)
      mask_d = (mask_q & ~wm[BTN_N-1:0])
             | (wb.wb_dat_i[BTN_N-1:0] & wm[BTN_N-1:0]);
    if (wr && hit_edge)
      edge_d = (edge_q & ~wm[BTN_N-1:0])
             | (wb.wb_dat_i[BTN_N-1:0] & wm[BTN_N-1:0]);
    if (wr && hit_pend)
      clr = wb.wb_dat_i[BTN_N-1:0] & wm[BTN_N-1:0];
  end

  // A new edge event overrides a same-cycle W1C.
  assign ev = (st_q & ~st_dly_q & ~edge_q)
            | (~st_q & st_dly_q & edge_q);
  assign pend_d = (pend_q & ~clr) | ev;

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < BTN_N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_s2_q[i] == st_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        st_d[i]  = btn_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      led_q    <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      st_q     <= '0;
      st_dly_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      for (int i = 0; i < BTN_N; i++)
        cnt_q[i] <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      led_q    <= led_d;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      st_q     <= st_d;
      st_dly_q <= st_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      for (int i = 0; i < BTN_N; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;
  assign wb.wb_dat_o = dat_q;
  assign led         = led_q;
  assign irq         = |(pend_q & mask_q);

endmodule

// File: tb/tb_wb_basicio_gen.sv
// Directed bench for wb_basicio_gen: register table plus
// debounce, interrupt, W1C race and reset corner sequences.
module tb_wb_basicio_gen;

  localparam int LED_W = 8;
  localparam int SW_W  = 8;
  localparam int BTN_N = 4;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  sw;
  logic [BTN_N-1:0] btn;
  logic             irq;

  int tests = 0;
  int fails = 0;

  wb_basicio_gen_if bus ();

  wb_basicio_gen #(
    .LED_W(LED_W), .SW_W(SW_W), .BTN_N(BTN_N),
    .DEB_CYCLES(4), .DEB_W(3)
  ) dut (
    .clk(clk), .reset(reset), .wb(bus.slave),
    .led(led), .sw(sw), .btn(btn), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic we, input logic [7:0] adr,
                      input logic [3:0] sel,
                      input logic [31:0] dat,
                      output logic [31:0] rdat);
    bit got = 0;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = {24'h0, adr};
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) got = 1;
    end
    rdat = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got 0 want 1 (adr %h)", adr);
    end
  endtask

  task automatic wr(input logic [7:0] adr,
                    input logic [3:0] sel,
                    input logic [31:0] dat);
    logic [31:0] d;
    xfer(1'b1, adr, sel, dat, d);
  endtask

  task automatic rd(input logic [7:0] adr,
                    output logic [31:0] d);
    xfer(1'b0, adr, 4'hF, 32'h0, d);
  endtask

  vec_t tbl [20];
  logic [31:0] r;
  logic [3:0]  ackpat;

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 4'h1, 32'h000000A5, 32'hA5};
    tbl[1]  = '{1'b1, 8'h00, 4'h2, 32'hFFFFFF00, 32'hA5};
    tbl[2]  = '{1'b0, 8'h00, 4'hF, 32'h0, 32'h000000A5};
    tbl[3]  = '{1'b0, 8'h04, 4'hF, 32'h0, 32'h0000003C};
    tbl[4]  = '{1'b0, 8'h20, 4'hF, 32'h0, 32'h00000000};
    tbl[5]  = '{1'b1, 8'h04, 4'hF, 32'h12345678, 32'hA5};
    tbl[6]  = '{1'b0, 8'h04, 4'h0, 32'h0, 32'h0000003C};
    tbl[7]  = '{1'b1, 8'h10, 4'hF, 32'hFFFFFFF0, 32'hA5};
    tbl[8]  = '{1'b0, 8'h10, 4'hF, 32'h0, 32'h00000000};
    tbl[9]  = '{1'b1, 8'h14, 4'hF, 32'h0000000A, 32'hA5};
    tbl[10] = '{1'b0, 8'h14, 4'hF, 32'h0, 32'h0000000A};
    tbl[11] = '{1'b1, 8'h14, 4'h0, 32'h0000000F, 32'hA5};
    tbl[12] = '{1'b0, 8'h14, 4'hF, 32'h0, 32'h0000000A};
    tbl[13] = '{1'b1, 8'h14, 4'h1, 32'h00000000, 32'hA5};
    tbl[14] = '{1'b0, 8'h14, 4'hF, 32'h0, 32'h00000000};
    tbl[15] = '{1'b0, 8'h08, 4'hF, 32'h0, 32'h00000000};
    tbl[16] = '{1'b0, 8'h0C, 4'hF, 32'h0, 32'h00000000};
    tbl[17] = '{1'b1, 8'h00, 4'hF, 32'h12345678, 32'h78};
    tbl[18] = '{1'b0, 8'h00, 4'hF, 32'h0, 32'h00000078};
    tbl[19] = '{1'b1, 8'h00, 4'h1, 32'h000000A5, 32'hA5};

    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    sw    = '0;
    btn   = '0;
    reset = 1'b1;
    tick(3);
    chk("rst_ack", 32'(bus.wb_ack_o), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    reset = 1'b0;

    sw = 8'h3C;
    tick(3);

    for (int i = 0; i < 20; i++) begin
      xfer(tbl[i].we, tbl[i].adr, tbl[i].sel,
           tbl[i].dat, r);
      if (tbl[i].we)
        chk($sformatf("vec%0d_led", i), 32'(led), tbl[i].exp);
      else
        chk($sformatf("vec%0d_rd", i), r, tbl[i].exp);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
    end

    // Held strobe: ack on alternate cycles only
    tick(1);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h0;
    bus.wb_sel_i = 4'h1;
    bus.wb_dat_i = 32'hA5;
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk);
      #1;
      ackpat[i] = bus.wb_ack_o;
    end
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    chk("ack_pattern", 32'(ackpat), 32'hA);
    tick(1);
    chk("ack_idle", 32'(bus.wb_ack_o), 32'h0);

    // Short pulse rejected
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(8);
    rd(8'h08, r);
    chk("pulse_btn", r, 32'h0);
    rd(8'h0C, r);
    chk("pulse_pend", r, 32'h0);

    // Exact latency, observed through irq with MASK[0]=1
    wr(8'h10, 4'h1, 32'h1);
    btn[0] = 1'b1;
    tick(6);
    chk("lat_irq_e6", 32'(irq), 32'h0);
    tick(1);
    chk("lat_irq_e7", 32'(irq), 32'h1);
    wr(8'h10, 4'h1, 32'h0);
    chk("masked_irq", 32'(irq), 32'h0);
    rd(8'h08, r);
    chk("btn_level", r, 32'h1);
    rd(8'h0C, r);
    chk("pend_set", r, 32'h1);
    wr(8'h10, 4'h1, 32'h1);
    chk("unmask_irq", 32'(irq), 32'h1);
    wr(8'h0C, 4'h1, 32'h1);
    rd(8'h0C, r);
    chk("w1c_pend", r, 32'h0);
    chk("w1c_irq", 32'(irq), 32'h0);

    // Falling-edge select on button 1
    wr(8'h14, 4'h1, 32'h2);
    btn[1] = 1'b1;
    tick(12);
    rd(8'h0C, r);
    chk("fall_press", r, 32'h0);
    btn[1] = 1'b0;
    tick(12);
    rd(8'h0C, r);
    chk("fall_release", r, 32'h2);
    wr(8'h0C, 4'h1, 32'h2);
    rd(8'h0C, r);
    chk("fall_clr", r, 32'h0);

    // W1C committed on the same edge as the rising event
    btn[2] = 1'b1;
    tick(6);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h0C;
    bus.wb_sel_i = 4'h1;
    bus.wb_dat_i = 32'h4;
    tick(1);
    chk("race_ack", 32'(bus.wb_ack_o), 32'h1);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    rd(8'h0C, r);
    chk("race_pend", r, 32'h4);
    wr(8'h0C, 4'h0, 32'h4);
    rd(8'h0C, r);
    chk("w1c_nosel", r, 32'h4);
    wr(8'h0C, 4'h1, 32'h4);
    rd(8'h0C, r);
    chk("w1c_sel", r, 32'h0);

    // PEND=0x3 then reset during a pending ack
    wr(8'h14, 4'h1, 32'h1);
    btn[0] = 1'b0;
    btn[1] = 1'b1;
    tick(12);
    rd(8'h0C, r);
    chk("pre_rst_pend", r, 32'h3);
    wr(8'h10, 4'h1, 32'h3);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk("pre_rst_led", 32'(led), 32'hA5);
    btn = '0;
    tick(1);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h0C;
    tick(1);
    chk("mid_ack", 32'(bus.wb_ack_o), 32'h1);
    chk("mid_dat", bus.wb_dat_o, 32'h3);
    reset = 1'b1;
    tick(1);
    chk("mrst_ack", 32'(bus.wb_ack_o), 32'h0);
    chk("mrst_led", 32'(led), 32'h0);
    chk("mrst_irq", 32'(irq), 32'h0);
    chk("mrst_dat", bus.wb_dat_o, 32'h0);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    reset = 1'b0;
    rd(8'h0C, r);
    chk("mrst_pend", r, 32'h0);
    rd(8'h10, r);
    chk("mrst_mask", r, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
